ult_minmax_tracker: RTL and testbench
=====================================

ULT_MINMAX_TRACKER -- requirements
Module: ult_minmax_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 3, data width of each unsigned sample.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the beat counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port I_valid  input  1  upstream sample valid.
REQ-006 SHALL have port I_ready  output  1  block can accept a sample.
REQ-007 SHALL have port I_data  input  WIDTH  unsigned sample.
REQ-008 SHALL have port I_last  input  1  marks final sample of a frame.
REQ-009 SHALL have port O_valid  output  1  frame result valid.
REQ-010 SHALL have port O_ready  input  1  downstream accepts result.
REQ-011 SHALL have port O_min  output  WIDTH  smallest unsigned sample of the frame.
REQ-012 SHALL have port O_max  output  WIDTH  largest unsigned sample of the frame.
REQ-013 SHALL have port O_count  output  CNT_WIDTH  number of samples in the frame, saturating.
REQ-014 SHALL have port O_sat  output  1  frame sample count saturated.

Function
REQ-015 SHALL implement a two-state FSM, ACCUM and HOLD; reset state ACCUM.
REQ-016 SHALL drive I_ready=1 in ACCUM and 0 in HOLD; a beat is accepted when I_valid and I_ready are both 1.
REQ-017 SHALL, on the first accepted beat of a frame, load both min and max accumulators with I_data.
REQ-018 SHALL, on each later accepted beat, replace min only if I_data is unsigned-less-than min, and replace max only if max is unsigned-less-than I_data; ties leave the accumulators unchanged.
REQ-019 SHALL increment the count on each accepted beat and hold it at all-ones once reached, setting the sat flag, which stays set until the frame ends.
REQ-020 SHALL, on an accepted beat with I_last=1, include that beat, register results to O_min/O_max/O_count/O_sat, and enter HOLD; O_valid SHALL be 1 the following cycle (latency 1).
REQ-021 SHALL hold O_valid and all result outputs stable in HOLD until O_ready=1; on that edge, go to ACCUM, deassert O_valid, and clear accumulators, count and sat flag.
REQ-022 SHALL accept no beat in the cycle O_ready releases HOLD; the next beat is accepted no earlier than the following cycle.
REQ-023 SHALL treat a single-beat frame (first beat with I_last=1) as min=max=I_data, count=1.
REQ-024 SHALL ignore I_data and I_last when the beat is not accepted.

Reset
REQ-025 SHALL, on ASYNCRESETN low, immediately force FSM to ACCUM, O_valid=0, O_min=0, O_max=0, O_count=0, O_sat=0, and clear accumulators, including mid-frame or in HOLD; a partial frame is discarded.
REQ-026 SHALL resume normal operation on the first rising CLK edge after ASYNCRESETN deasserts.

Configuration
REQ-027 SHALL, when macro ULT_MINMAX_INDEX_EN is defined, add outputs O_min_idx and O_max_idx (CNT_WIDTH each): zero-based beat index of the first occurrence of min/max, reset 0, captured with results, saturating at all-ones like the count.
REQ-028 SHALL, when ULT_MINMAX_INDEX_EN is undefined, omit those ports and their logic entirely, with other behaviour unchanged.

Verification (WIDTH=3, CNT_WIDTH=8)
REQ-029 SHALL verify frame 5,2,7,2(last), O_ready=1 -> O_valid one cycle after last, O_min=2, O_max=7, O_count=4, O_sat=0; with index enabled, min_idx=1, max_idx=2.
REQ-030 SHALL verify single beat 6(last) -> O_min=6, O_max=6, O_count=1.
REQ-031 SHALL verify O_ready=0 for 5 cycles after result -> O_valid and outputs stable, I_ready=0, I_valid beats not accepted.
REQ-032 SHALL verify 300 beats of value 3 then last -> O_count=255, O_sat=1, O_min=O_max=3.
REQ-033 SHALL verify ASYNCRESETN pulsed low mid-frame after beats 1,4 between edges -> outputs zero at once; next frame 0,7(last) yields O_min=0, O_max=7, O_count=2.
REQ-034 SHALL verify back-to-back frames with I_valid held high -> no beat accepted during HOLD or release cycle; second frame results independent of first.

Source files
------------

// File: rtl/ult_minmax_tracker.sv
// Frame-based unsigned min/max/count tracker with a valid/ready handshake on both sides.
// Define ULT_MINMAX_INDEX_EN to add first-occurrence beat indices of min and max.
module ult_minmax_tracker #(
  parameter int WIDTH     = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic [WIDTH-1:0]     I_data,
  input  logic                 I_last,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [WIDTH-1:0]     O_min,
  output logic [WIDTH-1:0]     O_max,
  output logic [CNT_WIDTH-1:0] O_count,
`ifdef ULT_MINMAX_INDEX_EN
  output logic [CNT_WIDTH-1:0] O_min_idx,
  output logic [CNT_WIDTH-1:0] O_max_idx,
`endif
  output logic                 O_sat
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [0:0]           state_q, state_d;
  logic [WIDTH-1:0]     min_q, min_d, max_q, max_d;
  logic [WIDTH-1:0]     omin_q, omin_d, omax_q, omax_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic                 sat_q, sat_d, osat_q, osat_d;
  logic                 accept, first_beat, new_min, new_max;

  // The count is zero only before the first beat of a frame, since it saturates rather than wraps.
  assign accept     = I_valid && (state_q == ACCUM);
  assign first_beat = (cnt_q == '0);
  assign new_min    = first_beat || (I_data < min_q);
  assign new_max    = first_beat || (max_q < I_data);

`ifdef ULT_MINMAX_INDEX_EN
  logic [CNT_WIDTH-1:0] mnidx_q, mnidx_d, mxidx_q, mxidx_d;
  logic [CNT_WIDTH-1:0] omnidx_q, omnidx_d, omxidx_q, omxidx_d;
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;
`ifdef ULT_MINMAX_INDEX_EN
    mnidx_d  = mnidx_q;
    mxidx_d  = mxidx_q;
    omnidx_d = omnidx_q;
    omxidx_d = omxidx_q;
`endif
    if (state_q == ACCUM) begin
      if (accept) begin
        if (new_min) min_d = I_data;
        if (new_max) max_d = I_data;
`ifdef ULT_MINMAX_INDEX_EN
        // The pre-increment count is this beat's zero-based index, saturating with the count.
        if (new_min) mnidx_d = cnt_q;
        if (new_max) mxidx_d = cnt_q;
`endif
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        sat_d = sat_q | (cnt_d == CNT_MAX);
        if (I_last) begin
          state_d = HOLD;
          omin_d  = min_d;
          omax_d  = max_d;
          ocnt_d  = cnt_d;
          osat_d  = sat_d;
`ifdef ULT_MINMAX_INDEX_EN
          omnidx_d = mnidx_d;
          omxidx_d = mxidx_d;
`endif
        end
      end
    end else if (O_ready) begin
      state_d = ACCUM;
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
`ifdef ULT_MINMAX_INDEX_EN
      mnidx_d = '0;
      mxidx_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ACCUM;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      omin_q  <= '0;
      omax_q  <= '0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
`ifdef ULT_MINMAX_INDEX_EN
      mnidx_q  <= '0;
      mxidx_q  <= '0;
      omnidx_q <= '0;
      omxidx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
`ifdef ULT_MINMAX_INDEX_EN
      mnidx_q  <= mnidx_d;
      mxidx_q  <= mxidx_d;
      omnidx_q <= omnidx_d;
      omxidx_q <= omxidx_d;
`endif
    end
  end

  assign I_ready = (state_q == ACCUM);
  assign O_valid = (state_q == HOLD);
  assign O_min   = omin_q;
  assign O_max   = omax_q;
  assign O_count = ocnt_q;
  assign O_sat   = osat_q;
`ifdef ULT_MINMAX_INDEX_EN
  assign O_min_idx = omnidx_q;
  assign O_max_idx = omxidx_q;
`endif

endmodule

// File: tb/tb_ult_minmax_tracker.sv
// Scoreboard bench for ult_minmax_tracker: frames are modelled as whole lists of samples.
module tb_ult_minmax_tracker;
  localparam int W    = 3;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN = 1'b0;
  logic          I_valid = 1'b0;
  logic          I_last = 1'b0;
  logic          O_ready = 1'b0;
  logic [W-1:0]  I_data = '0;
  logic          I_ready, O_valid, O_sat;
  logic [W-1:0]  O_min, O_max;
  logic [CW-1:0] O_count;
`ifdef ULT_MINMAX_INDEX_EN
  logic [CW-1:0] O_min_idx, O_max_idx;
`endif

  ult_minmax_tracker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_valid(I_valid), .I_ready(I_ready), .I_data(I_data), .I_last(I_last),
    .O_valid(O_valid), .O_ready(O_ready),
    .O_min(O_min), .O_max(O_max), .O_count(O_count),
`ifdef ULT_MINMAX_INDEX_EN
    .O_min_idx(O_min_idx), .O_max_idx(O_max_idx),
`endif
    .O_sat(O_sat)
  );

  always #5 CLK = ~CLK;

  typedef struct { int mn; int mx; int cnt; int sat; int mni; int mxi; } exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   gap_pct = 30;
  bit   stall_en = 1'b0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame result is a pure function of the whole sample list.
  function automatic exp_t model(input int d[$]);
    exp_t e;
    e.mn = d[0]; e.mx = d[0]; e.mni = 0; e.mxi = 0;
    foreach (d[i]) begin
      if (d[i] < e.mn) begin e.mn = d[i]; e.mni = i; end
      if (d[i] > e.mx) begin e.mx = d[i]; e.mxi = i; end
    end
    e.cnt = (d.size() > CMAX) ? CMAX : d.size();
    e.sat = (d.size() >= CMAX) ? 1 : 0;
    if (e.mni > CMAX) e.mni = CMAX;
    if (e.mxi > CMAX) e.mxi = CMAX;
    return e;
  endfunction

  // Downstream: random ready, or a forced 5-cycle stall once a result shows up.
  always @(negedge CLK) begin
    if (stall_en && O_valid === 1'b1 && stall_cnt < 5) begin
      O_ready = 1'b0;
      stall_cnt++;
    end else if (stall_en && stall_cnt >= 5) begin
      O_ready = 1'b1;
    end else begin
      O_ready = ($urandom_range(3) != 0);
      if (!stall_en) stall_cnt = 0;
    end
  end

  // Monitor: pop one expectation per result, then hold it for every HOLD cycle.
  bit   prev_v = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  always @(negedge CLK) begin
    if (O_valid === 1'b1) begin
      if (!prev_v) begin
        if (sb.size() == 0) begin
          tests++; fails++; have_cur = 1'b0;
          $display("FAIL unexpected_result: got O_valid=1 expected no pending frame at %0t", $time);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("O_min", 32'(O_min), cur.mn);
        check("O_max", 32'(O_max), cur.mx);
        check("O_count", 32'(O_count), cur.cnt);
        check("O_sat", 32'(O_sat), cur.sat);
`ifdef ULT_MINMAX_INDEX_EN
        check("O_min_idx", 32'(O_min_idx), cur.mni);
        check("O_max_idx", 32'(O_max_idx), cur.mxi);
`endif
      end
      check("hold_I_ready", 32'(I_ready), 0);
    end
    prev_v = (O_valid === 1'b1);
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input int d, input bit last, output bit ok);
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      I_valid = 1'b0; I_data = W'($urandom); I_last = 1'($urandom);
      @(negedge CLK);
    end
    I_valid = 1'b1; I_data = W'(d); I_last = last;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (I_ready === 1'b1) begin
        @(posedge CLK);
        @(negedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got I_ready=0 for 1000 cycles expected 1");
    end else begin
      #1 check("latency_O_valid", 32'(O_valid), 32'(last));
    end
  endtask

  task automatic send_frame(input int d[$]);
    bit ok;
    foreach (d[i]) begin
      if (i == d.size() - 1) sb.push_back(model(d));
      send_beat(d[i], (i == d.size() - 1), ok);
      if (!ok) return;
    end
  endtask

  task automatic rand_frame(input int maxlen);
    int d[$];
    int n = $urandom_range(maxlen, 1);
    for (int i = 0; i < n; i++) d.push_back($urandom_range((1 << W) - 1));
    send_frame(d);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (sb.size() == 0 && O_valid !== 1'b1) begin done = 1'b1; break; end
      @(negedge CLK);
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
  endtask

  initial begin
    int d[$];
    bit ok;
    #1;
    check("rst_O_valid", 32'(O_valid), 0);
    check("rst_I_ready", 32'(I_ready), 1);
    check("rst_O_min", 32'(O_min), 0);
    check("rst_O_max", 32'(O_max), 0);
    check("rst_O_count", 32'(O_count), 0);
    check("rst_O_sat", 32'(O_sat), 0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(negedge CLK);

    gap_pct = 0;
    d = '{5, 2, 7, 2}; send_frame(d);
    d = '{6};          send_frame(d);
    wait_drain();

    // Downstream stall with I_valid kept high throughout HOLD.
    stall_en = 1'b1;
    d = '{3, 1}; send_frame(d);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      check("stall_O_valid", 32'(O_valid), 1);
      check("stall_I_ready", 32'(I_ready), 0);
    end
    stall_en = 1'b0;
    wait_drain();

    gap_pct = 10;
    d.delete();
    for (int i = 0; i < 300; i++) d.push_back(3);
    d.push_back(3);
    send_frame(d);
    wait_drain();

    gap_pct = 30;
    for (int f = 0; f < 30; f++) rand_frame(12);
    gap_pct = 0;
    for (int f = 0; f < 20; f++) rand_frame(6);
    wait_drain();

    // Asynchronous reset between edges in the middle of a frame.
    send_beat(1, 1'b0, ok);
    send_beat(4, 1'b0, ok);
    #2 ASYNCRESETN = 1'b0; I_valid = 1'b0;
    #1;
    check("arst_O_valid", 32'(O_valid), 0);
    check("arst_O_min", 32'(O_min), 0);
    check("arst_O_max", 32'(O_max), 0);
    check("arst_O_count", 32'(O_count), 0);
    check("arst_O_sat", 32'(O_sat), 0);
    check("arst_I_ready", 32'(I_ready), 1);
    #1 ASYNCRESETN = 1'b1;
    @(negedge CLK);
    d = '{0, 7}; send_frame(d);
    wait_drain();

    I_valid = 1'b0;
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
